// File: rtl/posit_scale_unit.sv
// posit_scale_unit: combined-scale stage of the posit multiply/divide datapath.
//   Forms scale = k*2^ES + e for both operands, adds (MUL) or subtracts (DIV)
//   them, clamps to +/-((N-2)<<ES) and resolves NaR/zero specials.
// Latency: accept on edge E0, out_valid rises after E2; one operation in flight,
//   so at least 4 cycles separate accepts.
// Backpressure: in_ready is high only while IDLE; the result is held stable in
//   OUT until out_valid & out_ready.
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready, op_div, k_a/k_b (signed regime), e_a/e_b (exponent),
//   sign_a/b, nar_a/b, zero_a/b                        -- operand side
//   out_valid/out_ready, scale_out (signed SW bits), sign_out, nar_out,
//   zero_out, ovf_out, unf_out                         -- result side
// Optional build macro POSIT_SCALE_STATS_EN adds sat_clr (in) and sat_count
//   (out, 16 bits): saturating count of handshaken results with ovf/unf set.

module posit_scale_unit #(
  parameter int N      = 32,
  parameter int ES     = 3,
  parameter int K_BITS = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          op_div,
  input  logic signed [K_BITS-1:0]      k_a,
  input  logic signed [K_BITS-1:0]      k_b,
  input  logic [ES-1:0]                 e_a,
  input  logic [ES-1:0]                 e_b,
  input  logic                          sign_a,
  input  logic                          sign_b,
  input  logic                          nar_a,
  input  logic                          nar_b,
  input  logic                          zero_a,
  input  logic                          zero_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ES+K_BITS:0]     scale_out,
  output logic                          sign_out,
  output logic                          nar_out,
  output logic                          zero_out,
  output logic                          ovf_out,
  output logic                          unf_out
`ifdef POSIT_SCALE_STATS_EN
  ,
  input  logic                          sat_clr,
  output logic [15:0]                   sat_count
`endif
);

  localparam int SW        = ES + K_BITS + 1;
  localparam int SCALE_MAX = (N - 2) << ES;

  // Bounds at raw-sum width (SW+1) for comparison, and at output width for the
  // saturated value itself.
  localparam logic signed [SW:0]   RAW_MAX = (SW+1)'(SCALE_MAX);
  localparam logic signed [SW:0]   RAW_MIN = -RAW_MAX;
  localparam logic signed [SW-1:0] SAT_HI  = SW'(SCALE_MAX);
  localparam logic signed [SW-1:0] SAT_LO  = -SAT_HI;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CLASS = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state;

  // Operand capture registers
  logic               op_div_q;
  logic [K_BITS-1:0]  k_a_q;
  logic [K_BITS-1:0]  k_b_q;
  logic [ES-1:0]      e_a_q;
  logic [ES-1:0]      e_b_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic               nar_a_q;
  logic               nar_b_q;
  logic               zero_a_q;
  logic               zero_b_q;

  // Unclamped combined scale, one bit wider than the output so it never wraps
  logic signed [SW:0] raw_q;

  // Next-state datapath values
  logic signed [SW:0]   scale_a;
  logic signed [SW:0]   scale_b;
  logic signed [SW:0]   raw_nxt;
  logic                 nar_nxt;
  logic                 zero_nxt;
  logic                 ovf_nxt;
  logic                 unf_nxt;
  logic signed [SW-1:0] scale_nxt;
  logic                 sign_nxt;

  always_comb begin
    // Sign-extend the regime, shift it into the upper scale bits, then drop the
    // exponent into the low ES bits (they are zero after the shift).
    scale_a = ({{(SW+1-K_BITS){k_a_q[K_BITS-1]}}, k_a_q} << ES)
            + {{(SW+1-ES){1'b0}}, e_a_q};
    scale_b = ({{(SW+1-K_BITS){k_b_q[K_BITS-1]}}, k_b_q} << ES)
            + {{(SW+1-ES){1'b0}}, e_b_q};
    raw_nxt = op_div_q ? (scale_a - scale_b) : (scale_a + scale_b);
  end

  always_comb begin
    nar_nxt   = nar_a_q | nar_b_q | (op_div_q & zero_b_q);
    zero_nxt  = 1'b0;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    scale_nxt = '0;
    sign_nxt  = 1'b0;
    if (!nar_nxt) begin
      zero_nxt = op_div_q ? zero_a_q : (zero_a_q | zero_b_q);
      if (!zero_nxt) begin
        sign_nxt = sign_a_q ^ sign_b_q;
        // Out-of-range results saturate to maxpos/minpos scale; the exact
        // bounds themselves are representable and pass through unflagged.
        if (raw_q > RAW_MAX) begin
          scale_nxt = SAT_HI;
          ovf_nxt   = 1'b1;
        end else if (raw_q < RAW_MIN) begin
          scale_nxt = SAT_LO;
          unf_nxt   = 1'b1;
        end else begin
          scale_nxt = raw_q[SW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      scale_out <= '0;
      sign_out  <= 1'b0;
      nar_out   <= 1'b0;
      zero_out  <= 1'b0;
      ovf_out   <= 1'b0;
      unf_out   <= 1'b0;
      op_div_q  <= 1'b0;
      k_a_q     <= '0;
      k_b_q     <= '0;
      e_a_q     <= '0;
      e_b_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      nar_a_q   <= 1'b0;
      nar_b_q   <= 1'b0;
      zero_a_q  <= 1'b0;
      zero_b_q  <= 1'b0;
      raw_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_div_q <= op_div;
            k_a_q    <= k_a;
            k_b_q    <= k_b;
            e_a_q    <= e_a;
            e_b_q    <= e_b;
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            nar_a_q  <= nar_a;
            nar_b_q  <= nar_b;
            zero_a_q <= zero_a;
            zero_b_q <= zero_b;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          raw_q <= raw_nxt;
          state <= CLASS;
        end
        CLASS: begin
          scale_out <= scale_nxt;
          sign_out  <= sign_nxt;
          nar_out   <= nar_nxt;
          zero_out  <= zero_nxt;
          ovf_out   <= ovf_nxt;
          unf_out   <= unf_nxt;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef POSIT_SCALE_STATS_EN
  logic sat_hit;
  assign sat_hit = out_valid & out_ready & (ovf_out | unf_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (sat_hit && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_posit_scale_unit.sv
// Bench for posit_scale_unit: directed vectors, randomized operands against a
// plain-integer reference model, backpressure, mid-operation reset, and the
// optional saturation counter when POSIT_SCALE_STATS_EN is defined.

module tb_posit_scale_unit;

  localparam int SMAX = 240;  // (32-2)*2^3

  typedef struct packed {
    logic       div;
    logic [5:0] ka;
    logic [5:0] kb;
    logic [2:0] ea;
    logic [2:0] eb;
    logic       sa, sb, na, nb, za, zb;
  } op_t;

  typedef struct packed {
    logic signed [31:0] scale;
    logic sign, nar, zero, ovf, unf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic op_div = 1'b0;
  logic signed [5:0] k_a = '0, k_b = '0;
  logic [2:0] e_a = '0, e_b = '0;
  logic sign_a = 1'b0, sign_b = 1'b0, nar_a = 1'b0, nar_b = 1'b0;
  logic zero_a = 1'b0, zero_b = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [9:0] scale_out;
  logic sign_out, nar_out, zero_out, ovf_out, unf_out;
`ifdef POSIT_SCALE_STATS_EN
  logic sat_clr = 1'b0;
  logic [15:0] sat_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  posit_scale_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .op_div(op_div),
    .k_a(k_a), .k_b(k_b), .e_a(e_a), .e_b(e_b),
    .sign_a(sign_a), .sign_b(sign_b), .nar_a(nar_a), .nar_b(nar_b),
    .zero_a(zero_a), .zero_b(zero_b),
    .out_valid(out_valid), .out_ready(out_ready), .scale_out(scale_out),
    .sign_out(sign_out), .nar_out(nar_out), .zero_out(zero_out),
    .ovf_out(ovf_out), .unf_out(unf_out)
`ifdef POSIT_SCALE_STATS_EN
    , .sat_clr(sat_clr), .sat_count(sat_count)
`endif
  );

  function automatic res_t mk(int s, bit sg, bit na, bit ze, bit ov, bit un);
    res_t r;
    r.scale = s; r.sign = sg; r.nar = na; r.zero = ze; r.ovf = ov; r.unf = un;
    return r;
  endfunction

  function automatic op_t mkop(bit dv, int ka, int ea, int kb, int eb, bit sa, bit sb,
                               bit na, bit nb, bit za, bit zb);
    op_t o;
    o.div = dv; o.ka = 6'(ka); o.ea = 3'(ea); o.kb = 6'(kb); o.eb = 3'(eb);
    o.sa = sa; o.sb = sb; o.na = na; o.nb = nb; o.za = za; o.zb = zb;
    return o;
  endfunction

  // Reference: value of a posit scale in ordinary integers, then the rules.
  function automatic res_t model(op_t o);
    int ka, kb, a, b, raw;
    if (o.na || o.nb || (o.div && o.zb)) return mk(0, 0, 1, 0, 0, 0);
    if (o.div ? o.za : (o.za || o.zb))   return mk(0, 0, 0, 1, 0, 0);
    ka  = (int'(o.ka) >= 32) ? int'(o.ka) - 64 : int'(o.ka);
    kb  = (int'(o.kb) >= 32) ? int'(o.kb) - 64 : int'(o.kb);
    a   = ka * 8 + int'(o.ea);
    b   = kb * 8 + int'(o.eb);
    raw = o.div ? a - b : a + b;
    if (raw > SMAX)  return mk(SMAX, o.sa ^ o.sb, 0, 0, 1, 0);
    if (raw < -SMAX) return mk(-SMAX, o.sa ^ o.sb, 0, 0, 0, 1);
    return mk(raw, o.sa ^ o.sb, 0, 0, 0, 0);
  endfunction

  function automatic res_t observed();
    return mk(int'(scale_out), sign_out, nar_out, zero_out, ovf_out, unf_out);
  endfunction

  task automatic scramble();
    op_div = 1'($urandom); k_a = 6'($urandom); k_b = 6'($urandom);
    e_a = 3'($urandom); e_b = 3'($urandom); sign_a = 1'($urandom);
    sign_b = 1'($urandom); nar_a = 1'($urandom); nar_b = 1'($urandom);
    zero_a = 1'($urandom); zero_b = 1'($urandom);
  endtask

  // Presents o for one cycle (caller ensures in_ready), then garbage inputs.
  task automatic accept(input op_t o);
    op_div = o.div; k_a = o.ka; k_b = o.kb; e_a = o.ea; e_b = o.eb;
    sign_a = o.sa; sign_b = o.sb; nar_a = o.na; nar_b = o.nb;
    zero_a = o.za; zero_b = o.zb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  // Cycles from accept edge until out_valid; -1 if it never rises.
  task automatic wait_out(output res_t r, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    r = observed();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    n_tests++;
    if (observed() !== mk(0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_outs: scale=%0d flags s%b n%b z%b o%b u%b, want all 0",
               scale_out, sign_out, nar_out, zero_out, ovf_out, unf_out);
    end
`ifdef POSIT_SCALE_STATS_EN
    n_tests++;
    if (sat_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_sat_count: got %0d want 0", sat_count);
    end
`endif
    do_reset();
  endtask

  task automatic test_directed();
    op_t  ops[6];
    res_t exp[6];
    res_t r;
    int   lat;
    ops[0] = mkop(0, 2, 3, -1, 5, 1, 0, 0, 0, 0, 0);    exp[0] = mk(16, 1, 0, 0, 0, 0);
    ops[1] = mkop(1, 29, 7, -30, 0, 0, 0, 0, 0, 0, 0);  exp[1] = mk(240, 0, 0, 0, 1, 0);
    ops[2] = mkop(0, -30, 0, -30, 0, 0, 1, 0, 0, 0, 0); exp[2] = mk(-240, 1, 0, 0, 0, 1);
    ops[3] = mkop(0, -15, 0, -15, 0, 1, 1, 0, 0, 0, 0); exp[3] = mk(-240, 0, 0, 0, 0, 0);
    ops[4] = mkop(1, 3, 1, 2, 2, 1, 0, 0, 0, 0, 1);     exp[4] = mk(0, 0, 1, 0, 0, 0);
    ops[5] = mkop(0, 5, 5, 5, 5, 1, 0, 0, 1, 1, 0);     exp[5] = mk(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      accept(ops[i]);
      wait_out(r, lat);
      n_tests++;
      if (lat !== 2) begin
        n_fail++;
        $display("FAIL dir%0d_latency: got %0d want 2", i, lat);
      end
      n_tests++;
      if (r !== exp[i]) begin
        n_fail++;
        $display("FAIL dir%0d_result: got scale=%0d s%b n%b z%b o%b u%b want scale=%0d s%b n%b z%b o%b u%b",
                 i, r.scale, r.sign, r.nar, r.zero, r.ovf, r.unf,
                 exp[i].scale, exp[i].sign, exp[i].nar, exp[i].zero, exp[i].ovf, exp[i].unf);
      end
      drain();
    end
  endtask

  task automatic test_random();
    op_t  o;
    res_t r, e;
    int   lat;
    for (int i = 0; i < 60; i++) begin
      o.div = 1'($urandom); o.ka = 6'($urandom); o.kb = 6'($urandom);
      o.ea = 3'($urandom); o.eb = 3'($urandom);
      o.sa = 1'($urandom); o.sb = 1'($urandom);
      o.na = ($urandom_range(0, 15) == 0); o.nb = ($urandom_range(0, 15) == 0);
      o.za = ($urandom_range(0, 7) == 0);  o.zb = ($urandom_range(0, 7) == 0);
      e = model(o);
      out_ready = 1'($urandom);
      accept(o);
      wait_out(r, lat);
      n_tests++;
      if (lat !== 2 || r !== e) begin
        n_fail++;
        $display("FAIL rand%0d: lat=%0d scale=%0d s%b n%b z%b o%b u%b want lat=2 scale=%0d s%b n%b z%b o%b u%b",
                 i, lat, r.scale, r.sign, r.nar, r.zero, r.ovf, r.unf,
                 e.scale, e.sign, e.nar, e.zero, e.ovf, e.unf);
      end
      if (!out_ready) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    res_t r, e;
    int   lat;
    bit   bad = 0;
    op_t  o = mkop(0, 2, 3, -1, 5, 1, 0, 0, 0, 0, 0);
    e = mk(16, 1, 0, 0, 0, 0);
    out_ready = 1'b0;
    accept(o);
    wait_out(r, lat);
    n_tests++;
    if (r !== e || lat !== 2) begin
      n_fail++;
      $display("FAIL bp_result: lat=%0d scale=%0d want lat=2 scale=16", lat, r.scale);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (observed() !== e || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: scale=%0d out_valid=%b in_ready=%b want 16 1 0",
               scale_out, out_valid, in_ready);
    end
    drain();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    int   lat;
    bit   seen = 0;
    accept(mkop(1, 29, 7, -30, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;  // now in CALC
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_mid_discard: out_valid=1 seen, want 0");
    end
    accept(mkop(0, -15, 0, -15, 0, 1, 1, 0, 0, 0, 0));
    wait_out(r, lat);
    n_tests++;
    if (r !== mk(-240, 0, 0, 0, 0, 0) || lat !== 2) begin
      n_fail++;
      $display("FAIL rst_mid_next: lat=%0d scale=%0d ovf=%b unf=%b want lat=2 scale=-240 0 0",
               lat, r.scale, r.ovf, r.unf);
    end
    drain();
  endtask

`ifdef POSIT_SCALE_STATS_EN
  task automatic test_stats();
    res_t r;
    int   lat;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      accept(mkop(i == 1, 29, 7, (i == 1) ? -30 : 30, 0, 0, 0, 0, 0, 0, 0));
      wait_out(r, lat);
      drain();
    end
    accept(mkop(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));  // in range, no count
    wait_out(r, lat);
    drain();
    n_tests++;
    if (sat_count !== 16'd3) begin
      n_fail++;
      $display("FAIL stats_count: got %0d want 3", sat_count);
    end
    sat_clr = 1'b1;
    accept(mkop(0, -30, 0, -30, 0, 0, 0, 0, 0, 0, 0));
    wait_out(r, lat);
    drain();
    sat_clr = 1'b0;
    n_tests++;
    if (sat_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_clr: got %0d want 0", sat_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef POSIT_SCALE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
